// File: rtl/vector_lane_sequencer.sv
// rtl/vector_lane_sequencer.sv - element-serial vector instruction sequencer feeding NUM_LANES lanes
// One element per READ/LOAD/ISSUE round trip; lane completions are counted to retire the instruction.
package vector_lane_sequencer_pkg;
  parameter int VECTOR_REG_WIDTH  = 32;
  parameter int NUM_OF_VECTOR_REG = 32;
  typedef enum logic [2:0] {
    SADD = 3'd0, SSUB = 3'd1, SMUL = 3'd2, SDIV = 3'd3,
    FADD = 3'd4, FSUB = 3'd5, FMUL = 3'd6, FDIV = 3'd7
  } function_opcode_t;
endpackage

module vector_lane_sequencer
  import vector_lane_sequencer_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int VLEN      = 16,
  localparam int W  = VECTOR_REG_WIDTH,
  localparam int RW = $clog2(NUM_OF_VECTOR_REG),
  localparam int LW = $clog2(VLEN) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_vld,
  output logic                   instr_ready,
  input  function_opcode_t       instr_opcode,
  input  logic [RW-1:0]          instr_vd,
  input  logic [RW-1:0]          instr_vs1,
  input  logic [RW-1:0]          instr_vs2,
  input  logic [LW-1:0]          instr_vl,
  output logic                   rf_rd_en,
  output logic [RW-1:0]          rf_rd_reg0,
  output logic [RW-1:0]          rf_rd_reg1,
  output logic [LW-2:0]          rf_rd_idx,
  input  logic [W-1:0]           rf_rd_data0,
  input  logic [W-1:0]           rf_rd_data1,
  output logic [NUM_LANES-1:0]   lane_vld,
  output logic [NUM_LANES*W-1:0] lane_data0,
  output logic [NUM_LANES*W-1:0] lane_data1,
  output logic [RW-1:0]          lane_vec_reg,
  output function_opcode_t       lane_opcode,
  input  logic [NUM_LANES-1:0]   lane_busy,
  input  logic [NUM_LANES-1:0]   lane_result_vld,
  output logic                   instr_done,
  output logic                   instr_err
);
  localparam int PW = $clog2(NUM_LANES + 1);
  localparam int SW = ((LW > PW) ? LW : PW) + 1;

  typedef enum logic [2:0] {IDLE, READ, LOAD, ISSUE, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  function_opcode_t     opcode_q;
  logic [RW-1:0]        vd_q, vs1_q, vs2_q;
  logic [LW-1:0]        vl_q, elem_idx_q, done_cnt_q, cnt_next;
  logic [W-1:0]         op0_q, op1_q;
  logic                 err_q;
  logic                 accept, bad_instr, issue_fire, last_elem, drained;
  logic [NUM_LANES-1:0] tgt_oh;
  logic [PW-1:0]        pop;
  logic [SW-1:0]        cnt_sum;

  assign accept     = instr_vld && (state_q == IDLE);
  assign bad_instr  = !(instr_opcode inside {SADD, SSUB, SMUL, SDIV}) || (instr_vl > LW'(VLEN));
  assign issue_fire = (state_q == ISSUE) && !(|(lane_busy & tgt_oh));
  assign last_elem  = (elem_idx_q + LW'(1)) >= vl_q;

  always_comb begin
    tgt_oh = '0;
    pop    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      tgt_oh[i] = ((int'(elem_idx_q) % NUM_LANES) == i);
      pop       = pop + PW'(lane_result_vld[i]);
    end
  end

  // Completions are summed combinationally so DRAIN can retire on the cycle the last one lands.
  assign cnt_sum  = SW'(done_cnt_q) + SW'(pop);
  assign drained  = cnt_sum >= SW'(vl_q);
  assign cnt_next = drained ? vl_q : cnt_sum[LW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode_q   <= SADD;
      vd_q       <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      vl_q       <= '0;
      elem_idx_q <= '0;
      done_cnt_q <= '0;
      op0_q      <= '0;
      op1_q      <= '0;
      err_q      <= 1'b0;
    end else if (accept) begin
      opcode_q   <= instr_opcode;
      vd_q       <= instr_vd;
      vs1_q      <= instr_vs1;
      vs2_q      <= instr_vs2;
      vl_q       <= instr_vl;
      elem_idx_q <= '0;
      done_cnt_q <= '0;
      err_q      <= bad_instr;
    end else begin
      if (issue_fire) elem_idx_q <= elem_idx_q + LW'(1);
      if (state_q == LOAD) begin
        op0_q <= rf_rd_data0;
        op1_q <= rf_rd_data1;
      end
      if (state_q != IDLE && state_q != DONE) done_cnt_q <= cnt_next;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_vld) state_d = (bad_instr || instr_vl == '0) ? DONE : READ;
      READ:    state_d = LOAD;
      LOAD:    state_d = ISSUE;
      ISSUE:   if (issue_fire) state_d = last_elem ? DRAIN : READ;
      DRAIN:   if (drained) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_ready  = (state_q == IDLE);
    rf_rd_en     = 1'b0;
    rf_rd_reg0   = '0;
    rf_rd_reg1   = '0;
    rf_rd_idx    = '0;
    lane_vld     = '0;
    lane_data0   = '0;
    lane_data1   = '0;
    lane_vec_reg = '0;
    lane_opcode  = SADD;
    instr_done   = 1'b0;
    instr_err    = 1'b0;
    if (state_q == READ) begin
      rf_rd_en   = 1'b1;
      rf_rd_reg0 = vs1_q;
      rf_rd_reg1 = vs2_q;
      rf_rd_idx  = elem_idx_q[LW-2:0];
    end
    if (issue_fire) begin
      lane_vld     = tgt_oh;
      lane_vec_reg = vd_q;
      lane_opcode  = opcode_q;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_data0[i*W +: W] = tgt_oh[i] ? op0_q : '0;
        lane_data1[i*W +: W] = tgt_oh[i] ? op1_q : '0;
      end
    end
    if (state_q == DONE) begin
      instr_done = 1'b1;
      instr_err  = err_q;
    end
  end
endmodule

// File: tb/tb_vector_lane_sequencer.sv
// tb/tb_vector_lane_sequencer.sv - transaction-level model bench for vector_lane_sequencer
module tb_vector_lane_sequencer;
  import vector_lane_sequencer_pkg::*;

  localparam int NL = 4;
  localparam int VL = 16;
  localparam int W  = VECTOR_REG_WIDTH;
  localparam int NR = NUM_OF_VECTOR_REG;
  localparam int RW = $clog2(NR);
  localparam int LW = $clog2(VL) + 1;

  logic clk = 1'b0;
  logic reset;
  logic instr_vld, instr_ready;
  function_opcode_t instr_opcode;
  logic [RW-1:0] instr_vd, instr_vs1, instr_vs2;
  logic [LW-1:0] instr_vl;
  logic rf_rd_en;
  logic [RW-1:0] rf_rd_reg0, rf_rd_reg1;
  logic [LW-2:0] rf_rd_idx;
  logic [W-1:0] rf_rd_data0, rf_rd_data1;
  logic [NL-1:0] lane_vld;
  logic [NL*W-1:0] lane_data0, lane_data1;
  logic [RW-1:0] lane_vec_reg;
  function_opcode_t lane_opcode;
  logic [NL-1:0] lane_busy, lane_result_vld;
  logic instr_done, instr_err;

  vector_lane_sequencer #(.NUM_LANES(NL), .VLEN(VL)) dut (
    .clk(clk), .reset(reset),
    .instr_vld(instr_vld), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_vd(instr_vd), .instr_vs1(instr_vs1), .instr_vs2(instr_vs2), .instr_vl(instr_vl),
    .rf_rd_en(rf_rd_en), .rf_rd_reg0(rf_rd_reg0), .rf_rd_reg1(rf_rd_reg1), .rf_rd_idx(rf_rd_idx),
    .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
    .lane_vld(lane_vld), .lane_data0(lane_data0), .lane_data1(lane_data1),
    .lane_vec_reg(lane_vec_reg), .lane_opcode(lane_opcode),
    .lane_busy(lane_busy), .lane_result_vld(lane_result_vld),
    .instr_done(instr_done), .instr_err(instr_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] rf_mem [NR][VL];

  int cyc = 0;
  int m_act = 0, m_done_at = -1, m_err = 0, m_rd_cyc = 0, m_issued = 0, m_cnt = 0, m_vl = 0;
  int m_vd = 0, m_vs1 = 0, m_vs2 = 0;
  function_opcode_t m_op = SADD;
  int due_c [NL];
  int iss_cyc [VL];
  int acc_cyc = 0, last_done_cyc = 0;
  bit accepted_now = 0;
  int busy_mode = 0, busy_lane = 0, busy_from = 0, busy_to = -1;
  bit stray_en = 0, comp_rand = 0;
  bit rd_pend = 0;
  int rd_r0 = 0, rd_r1 = 0, rd_i = 0;

  task automatic model_clear();
    m_act = 0; m_done_at = -1; rd_pend = 0;
    for (int i = 0; i < NL; i++) due_c[i] = -1;
  endtask

  // One cycle: drive environment after the falling edge, check just after, then advance.
  task automatic step();
    int t;
    bit exp_rd, exp_iss, exp_ready;
    logic [NL*W-1:0] e0, e1;
    for (int i = 0; i < NL; i++) begin
      lane_result_vld[i] = (due_c[i] == cyc);
      if (due_c[i] == cyc) due_c[i] = -1;
      case (busy_mode)
        0:       lane_busy[i] = 1'b0;
        1:       lane_busy[i] = ($urandom_range(0, 3) == 0);
        default: lane_busy[i] = (i == busy_lane) && (cyc >= busy_from) && (cyc <= busy_to);
      endcase
    end
    if (stray_en && m_act == 0) lane_result_vld = lane_result_vld | NL'($urandom);
    rf_rd_data0 = rd_pend ? rf_mem[rd_r0][rd_i] : W'($urandom);
    rf_rd_data1 = rd_pend ? rf_mem[rd_r1][rd_i] : W'($urandom);
    rd_pend = 0;
    #1;
    exp_ready = (m_act == 0) && (cyc != m_done_at);
    exp_rd    = (m_act != 0) && (m_issued < m_vl) && (cyc == m_rd_cyc);
    t         = m_issued % NL;
    exp_iss   = (m_act != 0) && (m_issued < m_vl) && (cyc >= m_rd_cyc + 2) && !lane_busy[t];

    check_eq("instr_ready", instr_ready, exp_ready);
    check_eq("rf_rd_en", rf_rd_en, exp_rd);
    if (exp_rd) begin
      check_eq("rf_rd_reg0", rf_rd_reg0, m_vs1);
      check_eq("rf_rd_reg1", rf_rd_reg1, m_vs2);
      check_eq("rf_rd_idx", rf_rd_idx, m_issued);
    end
    check_eq("lane_vld", lane_vld, exp_iss ? (NL'(1) << t) : NL'(0));
    if (exp_iss) begin
      e0 = '0; e1 = '0;
      e0[t*W +: W] = rf_mem[m_vs1][m_issued];
      e1[t*W +: W] = rf_mem[m_vs2][m_issued];
      check_eq("lane_data0", lane_data0, e0);
      check_eq("lane_data1", lane_data1, e1);
      check_eq("lane_vec_reg", lane_vec_reg, m_vd);
      check_eq("lane_opcode", lane_opcode, m_op);
      iss_cyc[m_issued] = cyc;
      due_c[t] = cyc + (comp_rand ? int'($urandom_range(1, 4)) : 1);
      m_issued++;
      m_rd_cyc = cyc + 1;
    end
    if (m_act != 0) begin
      m_cnt += $countones(lane_result_vld);
      if (m_cnt >= m_vl) begin
        m_act = 0;
        m_done_at = cyc + 1;
      end
    end
    check_eq("instr_done", instr_done, cyc == m_done_at);
    if (cyc == m_done_at) check_eq("instr_err", instr_err, m_err);
    if (instr_done) last_done_cyc = cyc;
    if (rf_rd_en) begin
      rd_pend = 1; rd_r0 = rf_rd_reg0; rd_r1 = rf_rd_reg1; rd_i = rf_rd_idx;
    end
    accepted_now = 0;
    if (instr_vld && exp_ready) begin
      accepted_now = 1;
      acc_cyc = cyc;
      m_op = instr_opcode; m_vd = instr_vd; m_vs1 = instr_vs1; m_vs2 = instr_vs2; m_vl = instr_vl;
      m_err = !(m_op == SADD || m_op == SSUB || m_op == SMUL || m_op == SDIV) || (m_vl > VL);
      if (m_err != 0 || m_vl == 0) m_done_at = cyc + 1;
      else begin
        m_act = 1; m_rd_cyc = cyc + 1; m_issued = 0; m_cnt = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_instr(input function_opcode_t op, input int vd, input int vs1, input int vs2, input int vl);
    int guard;
    instr_vld = 1'b1; instr_opcode = op;
    instr_vd = RW'(vd); instr_vs1 = RW'(vs1); instr_vs2 = RW'(vs2); instr_vl = LW'(vl);
    guard = 0;
    do begin
      step();
      guard++;
    end while (!accepted_now && guard < 200);
    check_eq("accepted", accepted_now, 1'b1);
    instr_vld = 1'b0;
    instr_vl = LW'($urandom);
    guard = 0;
    while ((m_act != 0 || m_done_at >= cyc) && guard < 500) begin
      step();
      guard++;
    end
    check_eq("retired_in_time", (m_act == 0 && m_done_at < cyc), 1'b1);
  endtask

  initial begin
    for (int r = 0; r < NR; r++)
      for (int e = 0; e < VL; e++) rf_mem[r][e] = W'($urandom);
    for (int i = 0; i < NL; i++) due_c[i] = -1;
    reset = 1'b0; instr_vld = 1'b0; instr_opcode = SADD;
    instr_vd = '0; instr_vs1 = '0; instr_vs2 = '0; instr_vl = '0;
    rf_rd_data0 = '0; rf_rd_data1 = '0; lane_busy = '0; lane_result_vld = '0;
    @(negedge clk); @(negedge clk); #1;
    check_eq("rst_ready", instr_ready, 1'b1);
    check_eq("rst_rd_en", {rf_rd_en, rf_rd_reg0, rf_rd_reg1, rf_rd_idx}, '0);
    check_eq("rst_lane", {lane_vld, lane_data0, lane_data1, lane_vec_reg}, '0);
    check_eq("rst_opcode", lane_opcode, SADD);
    check_eq("rst_done", {instr_done, instr_err}, 2'b00);
    @(negedge clk);
    reset = 1'b1;

    // Basic four-element instruction with single-cycle lane turnaround
    run_instr(SADD, 3, 1, 2, 4);
    for (int k = 0; k < 4; k++) check_eq("sadd4_issue_cyc", iss_cyc[k] - acc_cyc, 3 + 3 * k);
    check_eq("sadd4_latency", last_done_cyc - acc_cyc, 14);

    run_instr(SSUB, 7, 4, 9, 6);
    check_eq("vl6_latency", last_done_cyc - acc_cyc, 20);

    // Lane 1 busy for five cycles from the first chance to issue element 1
    busy_mode = 2; busy_lane = 1; busy_from = cyc + 6; busy_to = cyc + 10;
    run_instr(SMUL, 5, 10, 11, 4);
    check_eq("stall_issue0", iss_cyc[0] - acc_cyc, 3);
    check_eq("stall_issue1", iss_cyc[1] - acc_cyc, 11);
    busy_mode = 0;

    run_instr(FADD, 1, 2, 3, 4);
    check_eq("fadd_err_latency", last_done_cyc - acc_cyc, 1);
    run_instr(SADD, 1, 2, 3, 17);
    check_eq("vl17_err_latency", last_done_cyc - acc_cyc, 1);
    run_instr(SADD, 1, 2, 3, 0);
    check_eq("vl0_latency", last_done_cyc - acc_cyc, 1);
    run_instr(SDIV, 8, 12, 13, 16);

    // Reset during the ISSUE cycle of element 2
    instr_vld = 1'b1; instr_opcode = SADD; instr_vd = RW'(6); instr_vs1 = RW'(1); instr_vs2 = RW'(2);
    instr_vl = LW'(4);
    step();
    check_eq("rst_mid_accepted", accepted_now, 1'b1);
    instr_vld = 1'b0;
    while (cyc < acc_cyc + 9) step();
    check_eq("rst_mid_elem", m_issued, 2);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_ready", instr_ready, 1'b1);
    check_eq("rst_mid_rd", {rf_rd_en, rf_rd_reg0, rf_rd_reg1, rf_rd_idx}, '0);
    check_eq("rst_mid_lane", {lane_vld, lane_data0, lane_data1, lane_vec_reg}, '0);
    check_eq("rst_mid_opcode", lane_opcode, SADD);
    check_eq("rst_mid_done", {instr_done, instr_err}, 2'b00);
    model_clear();
    @(negedge clk);
    cyc++;
    reset = 1'b1;
    repeat (4) step();
    run_instr(SADD, 2, 3, 4, 1);
    check_eq("post_rst_latency", last_done_cyc - acc_cyc, 5);

    // Randomized traffic: busy lanes, variable completion delay, stray idle completions
    busy_mode = 1; comp_rand = 1; stray_en = 1;
    for (int n = 0; n < 60; n++) begin
      function_opcode_t op;
      op = ($urandom_range(0, 9) < 8) ? function_opcode_t'($urandom_range(0, 3))
                                      : function_opcode_t'($urandom_range(4, 7));
      run_instr(op, int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
                int'($urandom_range(0, NR - 1)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(VL + 1, 2 * VL - 1))
                                            : int'($urandom_range(0, VL)));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
